// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int HDR_BYTES          = 2;
    localparam int BYTES_PER_WORD     = 4;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs little-endian bytes into 32-bit words; pulses word_complete with the finished word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete,
    output logic        last_byte
);
    logic [1:0] byte_cnt;

    assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            word          <= '0;
            byte_cnt      <= '0;
            word_complete <= 1'b0;
        end else begin
            word_complete <= byte_en && last_byte;
            if (byte_en) begin
                // shifting right leaves the first byte of the word in [7:0]
                word     <= {byte_in, word[31:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory and releases the CPU once the checksum matches.
//   state  | meaning
//   HDR_LO | waiting for word count low byte
//   HDR_HI | waiting for word count high byte
//   DATA   | receiving instruction bytes
//   CSUM   | waiting for checksum byte
//   DONE   | image good, CPU released
//   ERROR  | oversize count or bad checksum
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_wr_en,
    output logic [63:0] imem_addr,
    output logic [31:0] imem_wr_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);
    localparam int MAX_WORDS = 2 ** ADDR_WIDTH;

    state_t                 state, state_next;
    logic [8*HDR_BYTES-1:0] n_words;
    logic [8*HDR_BYTES-1:0] hdr_n;
    logic [ADDR_WIDTH:0]    word_index;
    logic [7:0]             csum;
    logic                   accept, data_en, last_byte, last_word;

    assign accept    = in_valid && in_ready;
    assign data_en   = accept && (state == DATA);
    assign hdr_n     = {in_data, n_words[7:0]};
    assign last_word = (32'(word_index) + 32'd1) == 32'(n_words);

    word_assembler u_word_assembler (
        .clk           (clk),
        .clear         (reset),
        .byte_en       (data_en),
        .byte_in       (in_data),
        .word          (imem_wr_data),
        .word_complete (imem_wr_en),
        .last_byte     (last_byte)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            HDR_LO: if (accept) state_next = HDR_HI;
            HDR_HI: if (accept) begin
                if (32'(hdr_n) > 32'(MAX_WORDS)) state_next = ERROR;
                else if (hdr_n == '0)            state_next = CSUM;
                else                             state_next = DATA;
            end
            DATA:   if (data_en && last_byte && last_word) state_next = CSUM;
            CSUM:   if (accept) state_next = (in_data == csum) ? DONE : ERROR;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HDR_LO;
            n_words    <= '0;
            word_index <= '0;
            csum       <= '0;
            imem_addr  <= '0;
            in_ready   <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state     <= state_next;
            // status outputs follow the state being entered so they change on the deciding edge
            in_ready  <= state_next inside {HDR_LO, HDR_HI, DATA, CSUM};
            cpu_reset <= (state_next != DONE);
            done      <= (state_next == DONE);
            error     <= (state_next == ERROR);
            if (accept && state == HDR_LO) n_words[7:0]  <= in_data;
            if (accept && state == HDR_HI) n_words[15:8] <= in_data;
            if (data_en) begin
                csum <= csum ^ in_data;
                if (last_byte) begin
                    imem_addr  <= 64'({word_index, 2'b00});
                    word_index <= word_index + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory before the pipelined CPU runs. It is the writer to the instruction-fetch reader. It takes a framed byte stream on a valid/ready input, assembles little-endian 32-bit instruction words, and writes them to consecutive word-aligned instruction-memory addresses. It holds the CPU in reset until the whole image is loaded and its checksum is verified.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address width of instruction memory; MAX_WORDS = 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte. A byte transfers on a posedge where in_valid && in_ready.
- imem_wr_en  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  64  byte address of the write; always {word_index, 2'b00}, zero-extended.
- imem_wr_data  out  32  instruction word.
- cpu_reset  out  1  reset to the CPU. High until a successful load completes.
- done  out  1  image loaded and checksum good.
- error  out  1  load aborted: word count too large or checksum mismatch.

## Operation
- Frame format:
  - 2-byte word count N, little-endian (low byte first).
  - 4·N data bytes; each word is little-endian, so the first byte goes to bits [7:0].
  - 1 checksum byte, equal to the XOR of all 4·N data bytes. Header bytes are excluded.
- States:
  - HDR_LO: capture N[7:0] → HDR_HI.
  - HDR_HI: capture N[15:8]. If N > MAX_WORDS → ERROR. If N == 0 → CSUM. Otherwise → DATA.
  - DATA: shift each byte into the assembler and XOR it into the running checksum. On the 4th byte of a word, issue the write and increment word_index. After word N−1 completes → CSUM.
  - CSUM: compare the received byte with the running XOR. Equal → DONE, otherwise → ERROR.
  - DONE, ERROR: terminal. Only reset exits.
- in_ready = 1 in HDR_LO, HDR_HI, DATA and CSUM; 0 in DONE and ERROR. The loader never stalls, because writes need no backpressure.
- Bytes only advance the state when accepted. Idle cycles (in_valid = 0) change nothing.
- Counters:
  - word_index is ADDR_WIDTH+1 bits wide, so N = MAX_WORDS is legal and the last address is (MAX_WORDS−1)·4.
  - The byte counter is 2 bits and wraps 3→0 at each word boundary.
- cpu_reset = 1 in every state except DONE. error = 1 only in ERROR. Memory contents already written on an error are left as they are.
- Reset mid-operation: return to HDR_LO and clear the counters, checksum and assembler. A partially loaded memory is not erased; the next frame overwrites from address 0.

## Timing
- Reset values: in_ready 0 during the reset cycle and 1 after it; imem_wr_en 0; imem_addr 0; imem_wr_data 0; cpu_reset 1; done 0; error 0.
- All outputs are registered.
- Write latency: if the 4th byte of word k is accepted at edge t, then imem_wr_en = 1, imem_addr = 4k and imem_wr_data = word k for exactly the cycle between edge t and edge t+1.
- Maximum write rate is one write per 4 cycles.
- Checksum byte accepted at edge t → done = 1 and cpu_reset = 0 from edge t. Mismatch → error = 1 from edge t, with cpu_reset still 1.
- Oversized N detected at the edge that accepts the HDR_HI byte → error = 1 and in_ready = 0 from that edge. No writes are issued.
- With N = 0, the checksum byte must be 0x00.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR);
  - HDR_BYTES = 2;
  - BYTES_PER_WORD = 4;
  - the default ADDR_WIDTH.
- Sub-module word_assembler: 4×8 shift register plus the 2-bit byte counter. It outputs the 32-bit word and a one-cycle word_complete pulse, and has a clear input driven by reset.
- The top level holds the FSM, word_index, the checksum register and the output registers.

## Test plan
- Single word: stream 01 00 13 00 80 D2 41 → one write, addr 0, data 0xD2800013. Then done = 1, cpu_reset = 0, in_ready = 0.
- N = 3 with random in_valid gaps → exactly three writes at addrs 0x0, 0x4 and 0x8 with the correct words, each write exactly one cycle after its 4th byte. After all three writes, done = 1.
- Empty image: stream 00 00 00 → no writes; done = 1 after the 3rd byte.
- Bad checksum: single-word frame with checksum 0x40 → one write to addr 0, then error = 1, cpu_reset = 1, in_ready = 0. Further valid bytes are ignored.
- Oversize with ADDR_WIDTH = 4: header 11 00 (N = 17) → error = 1 at the HDR_HI edge and no writes. Header 10 00 (N = 16) is accepted, and its last write goes to addr 0x3C.
- Reset mid-DATA after 2 data bytes, then a full single-word frame with word 0xAABBCCDD → exactly one write, addr 0, data 0xAABBCCDD. No stale bytes from the aborted word appear, and done = 1.
